latch_q_sampler: RTL
====================

// Module: latch_q_sampler
// PURPOSE
//  Downstream consumer of the cross-coupled-NAND gated D latch outputs (q, qb).
//  Synchronises q/qb into the clk domain and waits until they are complementary and stable.
//  Serialises one settled bit per sample request into a WIDTH-bit word with a valid/ready handshake.
//  Flags illegal (q==qb) and never-settling outputs for the timing-test bench.
// PARAMETERS
//  WIDTH        8   bits per output word; shifted in MSB-first
//  SYNC_STAGES  2   flops in each q/qb synchroniser chain (>=2)
//  SETTLE       2   consecutive qualifying cycles needed before a bit is captured (>=1)
//  TIMEOUT      16  max cycles spent in SETTLE before the bit is abandoned (>SETTLE)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      synchronous reset, active low
//  q           in   1      latch output, asynchronous to clk
//  qb          in   1      latch complementary output, asynchronous to clk
//  sample_en   in   1      request to capture one bit; honoured only in IDLE
//  word_data   out  WIDTH  assembled word; valid only while word_valid=1
//  word_valid  out  1      word available
//  word_ready  in   1      consumer accepts word
//  err_illegal out  1      1-cycle pulse for each SETTLE cycle with q_s==qb_s
//  err_timeout out  1      1-cycle pulse when SETTLE exceeds TIMEOUT
//  err_count   out  8      saturating count of illegal cycles
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge)
//   - State=IDLE; all sync flops, word_data, bit count, settle/timeout counters and err_count = 0.
//   - word_valid, err_*, busy = 0. Applies mid-operation: any partial word is discarded.
//  Synchroniser
//   - q_s / qb_s are the last stage of the chains. q_p holds the previous q_s.
//   - A qualifying cycle is q_s!=qb_s && q_s==q_p.
//  FSM
//   - IDLE:   sample_en=1 -> SETTLE; settle_cnt=0, tmo_cnt=0.
//   - SETTLE: every cycle tmo_cnt++.
//       - Qualifying cycle: settle_cnt++.
//       - Otherwise: settle_cnt=0. If q_s==qb_s, pulse err_illegal and increment err_count
//         (holds at 255, no wrap).
//       - On the SETTLE-th consecutive qualifying cycle: word_data <= {word_data[WIDTH-2:0], q_s};
//         bit_cnt++. If the new bit_cnt==WIDTH -> HOLD, else -> IDLE.
//       - Else if tmo_cnt reaches TIMEOUT-1 without capture: pulse err_timeout; no shift;
//         bit_cnt unchanged; -> IDLE.
//       - Capture and timeout in the same cycle: capture wins, no err_timeout.
//   - HOLD:   word_valid=1; word_data frozen; sample_en ignored.
//       - word_ready=1 -> IDLE, bit_cnt=0; word_valid deasserts on the next cycle.
//  Latency
//   - For inputs stable well before sample_en, the bit is captured at the edge ending
//     the SETTLE-th cycle after the sample_en cycle.
//   - Input changes reach q_s after SYNC_STAGES edges.
//  Misc
//   - sample_en outside IDLE is dropped, not queued.
//   - word_ready outside HOLD is ignored.
//   - word_data is not cleared after handoff; new bits shift over it.
//   - err_count clears only on reset.
// TESTING (WIDTH=8, SYNC_STAGES=2, SETTLE=2, TIMEOUT=16)
//  1. Reset: hold rst_n=0 for 2 clks with random q/qb -> all outputs 0, busy=0, err_count=0.
//  2. Stream 0xA5: for each bit, drive q=bit, qb=~bit for 4 clks, then a 1-clk sample_en.
//     -> Each bit is captured 2 clks after its sample_en.
//     -> word_valid=1 with word_data=8'hA5 after the 8th bit; word_ready=1 -> word_valid=0 next clk.
//  3. Illegal: q=qb=1 held through SETTLE for 3 synced cycles, then legal.
//     -> 3 err_illegal pulses and err_count=3; the bit is still captured once q/qb settle.
//  4. Timeout: q toggling every clk with qb=~q, then sample_en.
//     -> err_timeout pulses at the 16th SETTLE cycle; back in IDLE; bit_cnt unchanged.
//  5. Backpressure: in HOLD, word_ready=0 for 10 clks with sample_en pulses.
//     -> word_valid=1 and word_data constant throughout; no capture.
//     -> Raise word_ready: IDLE next clk.
//  6. Reset mid-word: assert rst_n=0 after 5 captured bits.
//     -> Everything is cleared; the next 8 bits form a fresh word with no residue.

Source files
------------

// File: rtl/latch_q_sampler.sv
// Samples the q/qb outputs of a gated D latch into the clk domain, waits for them to settle,
// and packs one settled bit per request into a WIDTH-bit word handed off with valid/ready.
module latch_q_sampler #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q,
  input  logic             qb,
  input  logic             sample_en,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [7:0]       err_count,
  output logic             busy
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE_ST = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] q_sync;
  logic [SYNC_STAGES-1:0] qb_sync;
  logic                   q_p;
  logic [SW-1:0]          settle_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [BW-1:0]          bit_cnt;

  logic q_s_c;
  logic qb_s_c;
  logic qual_c;
  logic illegal_c;
  logic capture_c;
  logic tmo_hit_c;
  logic last_bit_c;

  // Qualification: complementary and unchanged since the previous synced cycle.
  always_comb begin
    q_s_c      = q_sync[SYNC_STAGES-1];
    qb_s_c     = qb_sync[SYNC_STAGES-1];
    qual_c     = (q_s_c != qb_s_c) && (q_s_c == q_p);
    illegal_c  = (q_s_c == qb_s_c);
    capture_c  = qual_c && (settle_cnt == SW'(SETTLE - 1));
    tmo_hit_c  = (tmo_cnt == TW'(TIMEOUT - 1));
    last_bit_c = (bit_cnt == BW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_sync      <= '0;
      qb_sync     <= '0;
      q_p         <= 1'b0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      bit_cnt     <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= 8'd0;
      busy        <= 1'b0;
    end else begin
      q_sync      <= {q_sync[SYNC_STAGES-2:0], q};
      qb_sync     <= {qb_sync[SYNC_STAGES-2:0], qb};
      q_p         <= q_s_c;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (sample_en) begin
            state      <= SETTLE_ST;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            busy       <= 1'b1;
          end
        end

        SETTLE_ST: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (qual_c) begin
            settle_cnt <= settle_cnt + SW'(1);
          end else begin
            settle_cnt <= '0;
            if (illegal_c) begin
              err_illegal <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end

          // Capture takes priority over a timeout landing on the same cycle.
          if (capture_c) begin
            word_data <= {word_data[WIDTH-2:0], q_s_c};
            bit_cnt   <= bit_cnt + BW'(1);
            if (last_bit_c) begin
              state      <= HOLD;
              word_valid <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (tmo_hit_c) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end

        HOLD: begin
          if (word_ready) begin
            state      <= IDLE;
            word_valid <= 1'b0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          word_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
